// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 32-bit ALU between two requesters
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0_valid,
  input  logic [31:0]      i_req0_a,
  input  logic [31:0]      i_req0_b,
  input  logic [2:0]       i_req0_f,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [31:0]      i_req1_a,
  input  logic [31:0]      i_req1_b,
  input  logic [2:0]       i_req1_f,
  output logic             o_req1_ready,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_y,
  output logic             o_rsp_zero,
  output logic             o_rsp_id,
  output logic             o_rsp_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_done_cnt
);

  localparam logic [2:0] F_ILLEGAL = 3'b011;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_prio;
  logic [31:0]       r_op_a;
  logic [31:0]       r_op_b;
  logic [2:0]        r_op_f;
  logic              r_op_id;
  logic [31:0]       r_rsp_y;
  logic              r_rsp_zero;
  logic              r_rsp_id;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_done_cnt;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic              w_rsp_hs;
  logic [31:0]       w_diff;
  logic [31:0]       w_alu_y;

  // Grant: a lone valid wins outright, a tie goes to the priority pointer
  always_comb begin
    w_gnt0 = i_req0_valid && (!i_req1_valid || !r_prio);
    w_gnt1 = i_req1_valid && (!i_req0_valid || r_prio);
  end

  assign w_accept = o_req0_ready || o_req1_ready;
  assign w_rsp_hs = o_rsp_valid && i_rsp_ready;

  // Shared ALU, fed only from the captured operand registers; SLT is the sign of a-b
  always_comb begin
    w_diff = r_op_a - r_op_b;
    case (r_op_f)
      3'b000:  w_alu_y = r_op_a & r_op_b;
      3'b001:  w_alu_y = r_op_a | r_op_b;
      3'b010:  w_alu_y = r_op_a + r_op_b;
      3'b100:  w_alu_y = r_op_a & ~r_op_b;
      3'b101:  w_alu_y = r_op_a | ~r_op_b;
      3'b110:  w_alu_y = w_diff;
      3'b111:  w_alu_y = {31'd0, w_diff[31]};
      default: w_alu_y = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one EXEC cycle, RESP holds until the consumer takes it
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; grants are suppressed while reset is high
  always_comb begin
    o_req0_ready = (r_state == S_IDLE) && !i_reset && w_gnt0;
    o_req1_ready = (r_state == S_IDLE) && !i_reset && w_gnt1;
    o_rsp_valid  = (r_state == S_RESP);
    o_busy       = (r_state != S_IDLE);
  end

  // Operand capture, response registers, priority pointer and completion counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prio     <= 1'b0;
      r_op_a     <= 32'd0;
      r_op_b     <= 32'd0;
      r_op_f     <= 3'd0;
      r_op_id    <= 1'b0;
      r_rsp_y    <= 32'd0;
      r_rsp_zero <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op_a  <= o_req1_ready ? i_req1_a : i_req0_a;
        r_op_b  <= o_req1_ready ? i_req1_b : i_req0_b;
        r_op_f  <= o_req1_ready ? i_req1_f : i_req0_f;
        r_op_id <= o_req1_ready;
        r_prio  <= o_req0_ready;
      end
      if (r_state == S_EXEC) begin
        r_rsp_id <= r_op_id;
        if (r_op_f == F_ILLEGAL) begin
          r_rsp_y    <= 32'd0;
          r_rsp_zero <= 1'b1;
          r_rsp_err  <= 1'b1;
        end else begin
          r_rsp_y    <= w_alu_y;
          r_rsp_zero <= (w_alu_y == 32'd0);
          r_rsp_err  <= 1'b0;
        end
      end
      if (w_rsp_hs && (r_done_cnt != '1)) begin
        r_done_cnt <= r_done_cnt + CNT_ONE;
      end
    end
  end

  assign o_rsp_y    = r_rsp_y;
  assign o_rsp_zero = r_rsp_zero;
  assign o_rsp_id   = r_rsp_id;
  assign o_rsp_err  = r_rsp_err;
  assign o_done_cnt = r_done_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] y;
    logic        zero;
    logic        id;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } op_vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_f, req1_f;
  logic        rsp_ready;
  logic        req0_ready, req1_ready, rsp_valid, rsp_zero, rsp_id, rsp_err, busy;
  logic [31:0] rsp_y;
  logic [15:0] done_cnt;
  logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_zero, s_rsp_id, s_rsp_err, s_busy;
  logic [31:0] s_rsp_y;
  logic [1:0]  s_done_cnt;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  alu_arbiter #(.CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(req0_valid), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_f(req0_f),
    .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_f(req1_f),
    .o_req1_ready(req1_ready),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_y(rsp_y), .o_rsp_zero(rsp_zero),
    .o_rsp_id(rsp_id), .o_rsp_err(rsp_err), .o_busy(busy), .o_done_cnt(done_cnt)
  );

  alu_arbiter #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(req0_valid), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_f(req0_f),
    .o_req0_ready(s_req0_ready),
    .i_req1_valid(req1_valid), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_f(req1_f),
    .o_req1_ready(s_req1_ready),
    .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_y(s_rsp_y), .o_rsp_zero(s_rsp_zero),
    .o_rsp_id(s_rsp_id), .o_rsp_err(s_rsp_err), .o_busy(s_busy), .o_done_cnt(s_done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
  endtask

  // Drive one request, push its expected response when the bench sees it granted
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, input rsp_t e, output bit acc);
    acc = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
    end
    for (int i = 0; i < 12; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        acc = 1'b1;
        exp_q.push_back(e);
      end
      tick();
      if (acc) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, capture it and pop the expected entry
  task automatic collect(output rsp_t got, output rsp_t want, output bit to);
    to = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    got = {rsp_y, rsp_zero, rsp_id, rsp_err};
    if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = '1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_f = 3'b010;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    tick();
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready2 got %b want 00", {req0_ready, req1_ready}); end
    n_cmp++; if ({rsp_valid, busy, rsp_y, rsp_zero, rsp_id, rsp_err} !== 37'd0) begin n_bad++; $display("FAIL reset_outputs got v=%b busy=%b y=%h z=%b id=%b err=%b want all 0", rsp_valid, busy, rsp_y, rsp_zero, rsp_id, rsp_err); end
    n_cmp++; if (done_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", done_cnt); end
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    bit acc, to;
    rsp_t got, want;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_f = 3'b010;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    send(1'b0, 32'd5, 32'd3, 3'b010, {32'd8, 1'b0, 1'b0, 1'b0}, acc);
    n_cmp++; if (!acc) begin n_bad++; $display("FAIL single_accept got 0 want 1"); end
    n_cmp++; if ({rsp_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL single_exec got valid/busy=%b want 01", {rsp_valid, busy}); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency got valid=%b want 1", rsp_valid); end
    collect(got, want, to);
    n_cmp++; if (to || got !== want) begin n_bad++; $display("FAIL single_rsp got %h valid=%b want %h", got, rsp_valid, want); end
    tick();
    exp_cnt++;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drop got valid=%b want 0", rsp_valid); end
    n_cmp++; if (done_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL single_cnt got %0d want %0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_contention();
    bit m_prio;
    bit to;
    rsp_t got, want;
    do_reset();
    m_prio = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7;    req0_b = 32'd7;    req0_f = 3'b110;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_f = 3'b000;
    for (int g = 0; g < 4; g++) begin
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== (m_prio ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL contention_grant%0d got r1r0=%b want id %0d", g, {req1_ready, req0_ready}, m_prio); end
      exp_q.push_back({32'd0, 1'b1, m_prio, 1'b0});
      m_prio = ~m_prio;
      tick();
      tick();
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL contention_no_ready%0d got %b want 00", g, {req1_ready, req0_ready}); end
      collect(got, want, to);
      n_cmp++; if (to || got !== want) begin n_bad++; $display("FAIL contention_rsp%0d got %h valid=%b want %h", g, got, rsp_valid, want); end
      tick();
      exp_cnt++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++; if (done_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL contention_cnt got %0d want %0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    bit acc, to;
    rsp_t got, want;
    rsp_ready = 1'b0;
    send(1'b1, 32'h1234, 32'h0F0F, 3'b001, {32'h1F3F, 1'b0, 1'b1, 1'b0}, acc);
    n_cmp++; if (!acc) begin n_bad++; $display("FAIL bp_accept got 0 want 1"); end
    tick();
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_f = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_f = 3'b010;
    want = (exp_q.size() > 0) ? exp_q[0] : '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100) begin n_bad++; $display("FAIL bp_ctrl%0d got v/busy/r0/r1=%b want 1100", c, {rsp_valid, busy, req0_ready, req1_ready}); end
      n_cmp++; if ({rsp_y, rsp_zero, rsp_id, rsp_err} !== want) begin n_bad++; $display("FAIL bp_hold%0d got %h want %h", c, {rsp_y, rsp_zero, rsp_id, rsp_err}, want); end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    collect(got, want, to);
    n_cmp++; if (to || got !== want) begin n_bad++; $display("FAIL bp_rsp got %h valid=%b want %h", got, rsp_valid, want); end
    tick();
    exp_cnt++;
    n_cmp++; if (done_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL bp_cnt got %0d want %0d", done_cnt, exp_cnt); end
    tick();
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL bp_single got valid/busy=%b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_illegal();
    bit acc, to;
    rsp_t got, want;
    rsp_ready = 1'b1;
    send(1'b1, 32'd1, 32'd1, 3'b011, {32'd0, 1'b1, 1'b1, 1'b1}, acc);
    collect(got, want, to);
    n_cmp++; if (!acc || to || got !== want) begin n_bad++; $display("FAIL illegal_rsp got %h acc=%b want %h", got, acc, want); end
    tick();
    exp_cnt++;
    send(1'b0, 32'd2, 32'd3, 3'b111, {32'd1, 1'b0, 1'b0, 1'b0}, acc);
    collect(got, want, to);
    n_cmp++; if (!acc || to || got !== want) begin n_bad++; $display("FAIL after_illegal_rsp got %h acc=%b want %h", got, acc, want); end
    tick();
    exp_cnt++;
  endtask

  task automatic test_alu_ops();
    bit acc, to;
    rsp_t got, want;
    op_vec_t tbl[9];
    tbl[0] = '{3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00};
    tbl[1] = '{3'b001, 32'hF0000000, 32'h0000000F, 32'hF000000F};
    tbl[2] = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[3] = '{3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000};
    tbl[4] = '{3'b101, 32'h00000000, 32'hFFFFFFFE, 32'h00000001};
    tbl[5] = '{3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    tbl[6] = '{3'b111, 32'h80000000, 32'h00000001, 32'h00000000};
    tbl[7] = '{3'b111, 32'h00000005, 32'h00000007, 32'h00000001};
    tbl[8] = '{3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic id;
      id = 1'(i % 2);
      send(id, tbl[i].a, tbl[i].b, tbl[i].f, {tbl[i].y, (tbl[i].y == 32'd0), id, 1'b0}, acc);
      collect(got, want, to);
      n_cmp++; if (!acc || to || got !== want) begin n_bad++; $display("FAIL alu_op%0d f=%b got %h acc=%b want %h", i, tbl[i].f, got, acc, want); end
      tick();
      exp_cnt++;
    end
  endtask

  task automatic test_reset_mid_op();
    bit acc, to;
    rsp_t got, want;
    do_reset();
    send(1'b0, 32'd9, 32'd9, 3'b010, {32'd18, 1'b0, 1'b0, 1'b0}, acc);
    n_cmp++; if (!acc || busy !== 1'b1) begin n_bad++; $display("FAIL midrst_exec got acc=%b busy=%b want 1 1", acc, busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    n_cmp++; if ({rsp_valid, busy, rsp_y, rsp_zero, rsp_id, rsp_err} !== 37'd0) begin n_bad++; $display("FAIL midrst_outputs got v=%b busy=%b y=%h z=%b id=%b err=%b want all 0", rsp_valid, busy, rsp_y, rsp_zero, rsp_id, rsp_err); end
    n_cmp++; if (done_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_cnt got %0d want 0", done_cnt); end
    tick();
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp got valid=%b want 0", rsp_valid); end
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_f = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_f = 3'b010;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL midrst_prio got r1r0=%b want 01", {req1_ready, req0_ready}); end
    exp_q.push_back({32'd3, 1'b0, 1'b0, 1'b0});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    collect(got, want, to);
    n_cmp++; if (to || got !== want) begin n_bad++; $display("FAIL midrst_rsp got %h valid=%b want %h", got, rsp_valid, want); end
    tick();
    exp_cnt++;
  endtask

  task automatic test_saturation();
    bit acc, to;
    rsp_t got, want;
    int sat;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      logic id;
      id = 1'(k % 2);
      send(id, 32'(k), 32'd1, 3'b010, {32'(k + 1), 1'b0, id, 1'b0}, acc);
      collect(got, want, to);
      n_cmp++; if (!acc || to || got !== want) begin n_bad++; $display("FAIL sat_rsp%0d got %h acc=%b want %h", k, got, acc, want); end
      tick();
      exp_cnt++;
      sat = (exp_cnt > 3) ? 3 : exp_cnt;
      n_cmp++; if (s_done_cnt !== 2'(sat)) begin n_bad++; $display("FAIL sat_cnt2_op%0d got %0d want %0d", k, s_done_cnt, sat); end
      n_cmp++; if (done_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL sat_cnt16_op%0d got %0d want %0d", k, done_cnt, exp_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_f = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_f = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_alu_ops();
    test_reset_mid_op();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
